// File: rtl/mul_wb_tracker.sv
// Pairs untagged 5-stage multiplier results with their queued destination registers
// and merges them with the main-pipeline writeback onto the single register-file port.
module mul_wb_tracker #(
   parameter int DEPTH = 8,
   parameter int XLEN  = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   input  logic            mul_valid,
   input  logic [XLEN-1:0] mul_result,
   input  logic            wb_valid,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            rf_we,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            stall_out,
   output logic [31:0]     busy_mask,
   output logic            err_overflow,
   output logic            err_underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [4:0]      tag_q [DEPTH];
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]     count_q, count_d;

   logic            hold_valid_q, hold_valid_d;
   logic [4:0]      hold_rd_q, hold_rd_d;
   logic [XLEN-1:0] hold_data_q, hold_data_d;

   logic            rf_we_q, rf_we_d;
   logic [4:0]      rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

   logic            err_ovf_q, err_ovf_d;
   logic            err_unf_q, err_unf_d;

   logic            full, empty, pop_ok, push_ok;
   logic [4:0]      head_tag;
   logic [31:0]     busy_d;
   logic [AW-1:0]   offs;

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   // A simultaneous pop frees the slot, so a push into a full queue is still legal.
   assign pop_ok   = mul_valid && !empty;
   assign push_ok  = issue_valid && (!full || pop_ok);
   assign head_tag = tag_q[rd_ptr_q];

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      err_ovf_d = err_ovf_q;
      err_unf_d = err_unf_q;

      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (push_ok && !pop_ok) count_d = count_q + 1'b1;
      if (pop_ok && !push_ok) count_d = count_q - 1'b1;

      if (issue_valid && !push_ok) err_ovf_d = 1'b1;
      if (mul_valid && empty)      err_unf_d = 1'b1;
   end

   // Write-port arbitration: multiply result, then held writeback, then live writeback.
   always_comb begin
      rf_we_d      = 1'b0;
      rf_waddr_d   = rf_waddr_q;
      rf_wdata_d   = rf_wdata_q;
      hold_valid_d = hold_valid_q;
      hold_rd_d    = hold_rd_q;
      hold_data_d  = hold_data_q;

      if (pop_ok) begin
         if (head_tag != 5'd0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = head_tag;
            rf_wdata_d = mul_result;
         end
         if (wb_valid && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_rd_d    = wb_rd;
            hold_data_d  = wb_data;
         end
      end else if (hold_valid_q) begin
         rf_we_d      = 1'b1;
         rf_waddr_d   = hold_rd_q;
         rf_wdata_d   = hold_data_q;
         hold_valid_d = 1'b0;
      end else if (wb_valid) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = wb_rd;
         rf_wdata_d = wb_data;
      end
   end

   // An entry is live when its distance from the read pointer is below the count.
   always_comb begin
      busy_d = '0;
      offs   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs = AW'(i) - rd_ptr_q;
         if ({1'b0, offs} < count_q) busy_d[tag_q[i]] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // NOTE: the tag storage is deliberately not reset; the pointers and count alone define which entries are live.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (push_ok) tag_q[wr_ptr_q] <= issue_rd;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         hold_valid_q <= 1'b0;
         hold_rd_q    <= '0;
         hold_data_q  <= '0;
         rf_we_q      <= 1'b0;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
         err_ovf_q    <= 1'b0;
         err_unf_q    <= 1'b0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         hold_valid_q <= hold_valid_d;
         hold_rd_q    <= hold_rd_d;
         hold_data_q  <= hold_data_d;
         rf_we_q      <= rf_we_d;
         rf_waddr_q   <= rf_waddr_d;
         rf_wdata_q   <= rf_wdata_d;
         err_ovf_q    <= err_ovf_d;
         err_unf_q    <= err_unf_d;
      end
   end

   assign rf_we         = rf_we_q;
   assign rf_waddr      = rf_waddr_q;
   assign rf_wdata      = rf_wdata_q;
   assign stall_out     = hold_valid_q;
   assign busy_mask     = busy_d;
   assign err_overflow  = err_ovf_q;
   assign err_underflow = err_unf_q;

endmodule

// File: tb/tb_mul_wb_tracker.sv
// Directed-vector bench for mul_wb_tracker: each task drives one scenario and
// compares registered outputs one time unit after the rising edge.
module tb_mul_wb_tracker;

   logic        clock = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        mul_valid;
   logic [31:0] mul_result;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        stall_out;
   logic [31:0] busy_mask;
   logic        err_overflow;
   logic        err_underflow;

   int n_cmp = 0;
   int n_bad = 0;

   mul_wb_tracker #(.DEPTH(8), .XLEN(32)) dut (
      .clock(clock), .reset(reset),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .mul_valid(mul_valid), .mul_result(mul_result),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .stall_out(stall_out), .busy_mask(busy_mask),
      .err_overflow(err_overflow), .err_underflow(err_underflow)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      issue_valid = 1'b0; issue_rd = '0;
      mul_valid = 1'b0;   mul_result = '0;
      wb_valid = 1'b0;    wb_rd = '0; wb_data = '0;
   endtask

   task automatic cmp_rf(input string name, input logic we, input logic [4:0] a, input logic [31:0] d);
      n_cmp++;
      if ({rf_we, rf_waddr, rf_wdata} !== {we, a, d}) begin
         n_bad++;
         $display("FAIL %s: got we=%0b addr=%0d data=%h, want we=%0b addr=%0d data=%h",
                  name, rf_we, rf_waddr, rf_wdata, we, a, d);
      end
   endtask

   task automatic cmp_bit(input string name, input logic got, input logic want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0b, want %0b", name, got, want);
      end
   endtask

   task automatic cmp_busy(input string name, input logic [31:0] want);
      n_cmp++;
      if (busy_mask !== want) begin
         n_bad++;
         $display("FAIL %s: busy_mask got %h, want %h", name, busy_mask, want);
      end
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      cmp_rf("reset_rf", 1'b0, 5'd0, 32'h0);
      cmp_bit("reset_stall", stall_out, 1'b0);
      cmp_busy("reset_busy", 32'h0);
      cmp_bit("reset_ovf", err_overflow, 1'b0);
      cmp_bit("reset_unf", err_underflow, 1'b0);
   endtask

   task automatic test_single();
      issue_valid = 1'b1; issue_rd = 5'd5;
      step();
      idle();
      cmp_busy("single_busy", 32'h0000_0020);
      repeat (4) step();
      cmp_rf("single_nowrite", 1'b0, 5'd0, 32'h0);
      mul_valid = 1'b1; mul_result = 32'h0000_002A;
      step();
      idle();
      cmp_rf("single_write", 1'b1, 5'd5, 32'h2A);
      cmp_busy("single_busy_clr", 32'h0);
      step();
      cmp_rf("single_hold_last", 1'b0, 5'd5, 32'h2A);
   endtask

   task automatic test_order();
      logic [4:0]  rds [3];
      logic [31:0] res [3];
      rds = '{5'd3, 5'd7, 5'd9};
      res = '{32'h11, 32'h22, 32'h33};
      for (int i = 0; i < 3; i++) begin
         issue_valid = 1'b1; issue_rd = rds[i];
         step();
      end
      idle();
      cmp_busy("order_busy", 32'h0000_0288);
      for (int i = 0; i < 3; i++) begin
         mul_valid = 1'b1; mul_result = res[i];
         step();
         cmp_rf($sformatf("order_write%0d", i), 1'b1, rds[i], res[i]);
      end
      idle();
      cmp_busy("order_busy_clr", 32'h0);
   endtask

   task automatic test_conflict();
      issue_valid = 1'b1; issue_rd = 5'd4;
      step();
      idle();
      mul_valid = 1'b1; mul_result = 32'hAAAA;
      wb_valid = 1'b1; wb_rd = 5'd8; wb_data = 32'h1234;
      step();
      cmp_rf("conf_mul", 1'b1, 5'd4, 32'hAAAA);
      cmp_bit("conf_stall", stall_out, 1'b1);
      idle();
      wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'h5555;
      step();
      idle();
      cmp_rf("conf_drain", 1'b1, 5'd8, 32'h1234);
      cmp_bit("conf_stall_clr", stall_out, 1'b0);
      step();
      cmp_rf("conf_stalled_wb_ignored", 1'b0, 5'd8, 32'h1234);
   endtask

   task automatic test_back_to_back();
      issue_valid = 1'b1; issue_rd = 5'd11; step();
      issue_rd = 5'd12; step();
      idle();
      mul_valid = 1'b1; mul_result = 32'h111;
      wb_valid = 1'b1; wb_rd = 5'd13; wb_data = 32'h77;
      step();
      cmp_rf("b2b_mul0", 1'b1, 5'd11, 32'h111);
      idle();
      mul_valid = 1'b1; mul_result = 32'h222;
      step();
      cmp_rf("b2b_mul1", 1'b1, 5'd12, 32'h222);
      cmp_bit("b2b_still_stalled", stall_out, 1'b1);
      idle();
      step();
      cmp_rf("b2b_drain", 1'b1, 5'd13, 32'h77);
      cmp_bit("b2b_stall_clr", stall_out, 1'b0);
   endtask

   task automatic test_x0();
      issue_valid = 1'b1; issue_rd = 5'd0;
      step();
      idle();
      cmp_busy("x0_busy", 32'h0);
      mul_valid = 1'b1; mul_result = 32'h99;
      step();
      idle();
      cmp_rf("x0_nowrite", 1'b0, 5'd13, 32'h77);
      issue_valid = 1'b1; issue_rd = 5'd6;
      step();
      idle();
      cmp_busy("x0_next_busy", 32'h0000_0040);
      mul_valid = 1'b1; mul_result = 32'h66;
      step();
      idle();
      cmp_rf("x0_next_write", 1'b1, 5'd6, 32'h66);
   endtask

   task automatic test_full();
      logic [4:0] exp_rd [8];
      exp_rd = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd20};
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         issue_valid = 1'b1; issue_rd = 5'(i);
         step();
      end
      idle();
      cmp_busy("full_busy", 32'h0000_01FE);
      issue_valid = 1'b1; issue_rd = 5'd20;
      mul_valid = 1'b1; mul_result = 32'h100;
      step();
      idle();
      cmp_rf("full_pushpop_write", 1'b1, 5'd1, 32'h100);
      cmp_bit("full_pushpop_no_ovf", err_overflow, 1'b0);
      cmp_busy("full_pushpop_busy", 32'h0010_01FC);
      issue_valid = 1'b1; issue_rd = 5'd21;
      step();
      idle();
      cmp_bit("full_ovf", err_overflow, 1'b1);
      cmp_busy("full_ovf_busy", 32'h0010_01FC);
      for (int i = 0; i < 8; i++) begin
         mul_valid = 1'b1; mul_result = 32'h200 + 32'(i);
         step();
         cmp_rf($sformatf("full_drain%0d", i), 1'b1, exp_rd[i], 32'h200 + 32'(i));
      end
      idle();
      cmp_busy("full_empty_busy", 32'h0);
      cmp_bit("full_no_unf", err_underflow, 1'b0);
   endtask

   task automatic test_underflow();
      mul_valid = 1'b1; mul_result = 32'hDEAD;
      step();
      idle();
      cmp_bit("unf_flag", err_underflow, 1'b1);
      cmp_rf("unf_nowrite", 1'b0, 5'd20, 32'h207);
      step();
      cmp_bit("unf_sticky", err_underflow, 1'b1);
      cmp_bit("ovf_sticky", err_overflow, 1'b1);
   endtask

   task automatic test_reset_mid();
      for (int i = 2; i <= 5; i++) begin
         issue_valid = 1'b1; issue_rd = 5'(i);
         step();
      end
      idle();
      mul_valid = 1'b1; mul_result = 32'hA;
      wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'hB;
      step();
      idle();
      cmp_rf("mid_pre_write", 1'b1, 5'd2, 32'hA);
      cmp_bit("mid_pre_stall", stall_out, 1'b1);
      cmp_busy("mid_pre_busy", 32'h0000_0038);
      reset = 1'b1;
      step();
      reset = 1'b0;
      cmp_rf("mid_rf", 1'b0, 5'd0, 32'h0);
      cmp_bit("mid_stall", stall_out, 1'b0);
      cmp_busy("mid_busy", 32'h0);
      cmp_bit("mid_ovf", err_overflow, 1'b0);
      cmp_bit("mid_unf", err_underflow, 1'b0);
      step();
      cmp_rf("mid_hold_discarded", 1'b0, 5'd0, 32'h0);
      mul_valid = 1'b1; mul_result = 32'hC;
      step();
      idle();
      cmp_bit("mid_queue_empty", err_underflow, 1'b1);
      cmp_rf("mid_queue_empty_nowrite", 1'b0, 5'd0, 32'h0);
   endtask

   initial begin
      idle();
      reset = 1'b1;
      test_reset();
      test_single();
      test_order();
      test_conflict();
      test_back_to_back();
      test_x0();
      test_full();
      test_underflow();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
